// File: rtl/dmi_dtm_pkg.sv
// dmi_dtm_pkg: shared types and constants for the DMI transport controller.
//   state_e     : controller FSM states (Idle / Req / Wait)
//   OP_*        : DMI operation encodings
//   STAT_*      : DMI response / dmistat encodings
//   DTM_VERSION : value reported in dtmcs.version
//   FILL_*      : data words substituted for read data on failed or busy ops
package dmi_dtm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   localparam logic [1:0] STAT_OK   = 2'd0;
   localparam logic [1:0] STAT_FAIL = 2'd2;
   localparam logic [1:0] STAT_BUSY = 2'd3;

   localparam logic [3:0] DTM_VERSION = 4'd1;

   localparam logic [31:0] FILL_FAIL = 32'hDEADBEEF;
   localparam logic [31:0] FILL_BUSY = 32'hB051B051;

endpackage

// File: rtl/dmi_dtm_shreg.sv
// dmi_dtm_shreg: TAP data-register capture/shift register of width W.
//   clk_i, rst_i  : clock, async active-high reset
//   clear_i       : synchronous clear (highest priority)
//   capture_i     : parallel load of cap_data_i
//   shift_i       : shift right one bit, tdi_i enters at the MSB
//   data_o        : current register contents (read at Update-DR)
//   tdo_o         : register LSB
module dmi_dtm_shreg #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         capture_i,
   input  logic         shift_i,
   input  logic         tdi_i,
   input  logic [W-1:0] cap_data_i,
   output logic [W-1:0] data_o,
   output logic         tdo_o
);

   logic [W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (clear_i) begin
         sr_d = '0;
      end else if (capture_i) begin
         sr_d = cap_data_i;
      end else if (shift_i) begin
         sr_d = {tdi_i, sr_q[W-1:1]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign data_o = sr_q;
   assign tdo_o  = sr_q[0];

endmodule

// File: rtl/dmi_dtm_ctrl.sv
// dmi_dtm_ctrl: DMI transport controller behind the JTAG TAP.
// Owns the dtmcs and dmi data registers, the sticky dmistat error, a
// saturating busy-event counter and the Idle/Req/Wait FSM that issues one
// DMI operation and collects its response.
// Optional build macro: DMI_RESP_TIMEOUT_EN -- abandons an op that sits in
// Wait for TIMEOUT_CYC cycles without a response.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   dmi_clear_i                   TAP Test-Logic-Reset (synchronous hard clear)
//   capture_i/shift_i/update_i    single-cycle TAP DR strobes, tdi_i serial in
//   dtmcs_select_i/dmi_select_i   IR decode for the two data registers
//   dtmcs_tdo_o/dmi_tdo_o         data register LSBs
//   dmi_req_*                     request channel (valid/ready, addr, data, op)
//   dmi_resp_*                    response channel (ready is tied high)
//   error_o                       sticky dmistat
//   busy_cnt_o                    saturating busy-event count
module dmi_dtm_ctrl
   import dmi_dtm_pkg::*;
#(
   parameter int unsigned ABITS       = 7,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned IDLE_HINT   = 1,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              dmi_clear_i,
   input  logic              capture_i,
   input  logic              shift_i,
   input  logic              update_i,
   input  logic              tdi_i,
   input  logic              dtmcs_select_i,
   input  logic              dmi_select_i,
   output logic              dtmcs_tdo_o,
   output logic              dmi_tdo_o,
   output logic              dmi_req_valid_o,
   input  logic              dmi_req_ready_i,
   output logic [ABITS-1:0]  dmi_req_addr_o,
   output logic [DATA_W-1:0] dmi_req_data_o,
   output logic [1:0]        dmi_req_op_o,
   input  logic              dmi_resp_valid_i,
   output logic              dmi_resp_ready_o,
   input  logic [DATA_W-1:0] dmi_resp_data_i,
   input  logic [1:0]        dmi_resp_resp_i,
   output logic [1:0]        error_o,
   output logic [CNT_W-1:0]  busy_cnt_o
);

   localparam int unsigned W = ABITS + DATA_W + 2;

   state_e            state_q, state_d;
   logic [ABITS-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic [1:0]        err_q, err_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;

   logic              dtmcs_cap, dtmcs_sft, dtmcs_upd;
   logic              dmi_cap, dmi_sft, dmi_upd;
   logic              hard_clr, dmi_rst, busy_evt, tmo_hit;
   logic [31:0]       dtmcs_cap_val, dtmcs_dr;
   logic [W-1:0]      dmi_cap_val, dmi_dr;
   logic [1:0]        cap_stat, new_err;
   logic              unused_dtmcs;

   assign dtmcs_cap = capture_i & dtmcs_select_i;
   assign dtmcs_sft = shift_i   & dtmcs_select_i;
   assign dtmcs_upd = update_i  & dtmcs_select_i;
   assign dmi_cap   = capture_i & dmi_select_i;
   assign dmi_sft   = shift_i   & dmi_select_i;
   assign dmi_upd   = update_i  & dmi_select_i;

   // dtmcs bit17 = dmihardreset, bit16 = dmireset
   assign hard_clr = dmi_clear_i | (dtmcs_upd & dtmcs_dr[17]);
   assign dmi_rst  = dtmcs_upd & dtmcs_dr[16];

   // Busy: an update the FSM cannot take, or a capture that would read
   // stale data because a read is still outstanding.
   assign busy_evt = (dmi_upd & (state_q != ST_IDLE)) |
                     (dmi_cap & ~we_q & ((state_q == ST_REQ) | (state_q == ST_WAIT)));

   assign dtmcs_cap_val = {14'b0, 1'b0, 1'b0, 1'b0, 3'(IDLE_HINT), err_q,
                           6'(ABITS), DTM_VERSION};

   always_comb begin
      cap_stat = STAT_OK;
      if ((err_q == STAT_BUSY) || busy_evt) begin
         cap_stat = STAT_BUSY;
      end else if (err_q == STAT_FAIL) begin
         cap_stat = STAT_FAIL;
      end
   end

   assign dmi_cap_val = {addr_q, data_q, cap_stat};

   dmi_dtm_shreg #(.W(32)) u_dtmcs_sr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (hard_clr),
      .capture_i  (dtmcs_cap),
      .shift_i    (dtmcs_sft),
      .tdi_i      (tdi_i),
      .cap_data_i (dtmcs_cap_val),
      .data_o     (dtmcs_dr),
      .tdo_o      (dtmcs_tdo_o)
   );

   dmi_dtm_shreg #(.W(W)) u_dmi_sr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (hard_clr),
      .capture_i  (dmi_cap),
      .shift_i    (dmi_sft),
      .tdi_i      (tdi_i),
      .cap_data_i (dmi_cap_val),
      .data_o     (dmi_dr),
      .tdo_o      (dmi_tdo_o)
   );

   assign unused_dtmcs = ^{dtmcs_dr[31:18], dtmcs_dr[15:0]};

`ifdef DMI_RESP_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TO_W-1:0] tmo_q, tmo_d;

   // Held at zero outside Wait, so it starts from zero on every Wait entry.
   assign tmo_d   = (state_q == ST_WAIT) ? tmo_q + TO_W'(1) : '0;
   assign tmo_hit = (state_q == ST_WAIT) && (tmo_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      err_d   = err_q;
      bcnt_d  = bcnt_q;
      new_err = STAT_OK;

      case (state_q)
         ST_IDLE: begin
            if (dmi_upd && (err_q == STAT_OK)) begin
               addr_d = dmi_dr[W-1 -: ABITS];
               data_d = dmi_dr[2 +: DATA_W];
               if ((dmi_dr[1:0] == OP_READ) || (dmi_dr[1:0] == OP_WRITE)) begin
                  we_d    = (dmi_dr[1:0] == OP_WRITE);
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (dmi_req_ready_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmi_resp_valid_i) begin
               state_d = ST_IDLE;
               case (dmi_resp_resp_i)
                  STAT_OK: begin
                     if (!we_q) data_d = dmi_resp_data_i;
                  end
                  STAT_BUSY: begin
                     if (!we_q) data_d = DATA_W'(FILL_BUSY);
                     new_err = STAT_BUSY;
                  end
                  default: begin
                     if (!we_q) data_d = DATA_W'(FILL_FAIL);
                     new_err = STAT_FAIL;
                  end
               endcase
            end else if (tmo_hit) begin
               state_d = ST_IDLE;
               if (!we_q) data_d = DATA_W'(FILL_FAIL);
               new_err = STAT_FAIL;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Busy outranks a same-cycle response status; only the first error sticks.
      if (busy_evt) begin
         new_err = STAT_BUSY;
         if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
      end
      if ((err_q == STAT_OK) && (new_err != STAT_OK)) begin
         err_d = new_err;
      end
      if (dmi_rst) begin
         err_d = STAT_OK;
      end

      if (hard_clr) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         data_d  = '0;
         we_d    = 1'b0;
         err_d   = STAT_OK;
         bcnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= STAT_OK;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         err_q   <= err_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign dmi_req_valid_o  = (state_q == ST_REQ);
   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_data_o   = data_q;
   assign dmi_req_op_o     = we_q ? OP_WRITE : OP_READ;
   assign dmi_resp_ready_o = 1'b1;
   assign error_o          = err_q;
   assign busy_cnt_o       = bcnt_q;

endmodule

// File: tb/tb_dmi_dtm_ctrl.sv
// tb_dmi_dtm_ctrl: directed bench for dmi_dtm_ctrl.
// Expected captures and expected bus requests are queued when stimulus is
// driven and popped when the DUT shifts data out or issues a request.
// The timeout section is built only when DMI_RESP_TIMEOUT_EN is defined.
module tb_dmi_dtm_ctrl;

   localparam int unsigned ABITS  = 7;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned W      = ABITS + DATA_W + 2;
   localparam int unsigned CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              dmi_clear_i = 1'b0;
   logic              capture_i = 1'b0, shift_i = 1'b0, update_i = 1'b0, tdi_i = 1'b0;
   logic              dtmcs_select_i = 1'b0, dmi_select_i = 1'b0;
   logic              dtmcs_tdo_o, dmi_tdo_o;
   logic              dmi_req_valid_o;
   logic              dmi_req_ready_i = 1'b0;
   logic [ABITS-1:0]  dmi_req_addr_o;
   logic [DATA_W-1:0] dmi_req_data_o;
   logic [1:0]        dmi_req_op_o;
   logic              dmi_resp_valid_i = 1'b0;
   logic              dmi_resp_ready_o;
   logic [DATA_W-1:0] dmi_resp_data_i = '0;
   logic [1:0]        dmi_resp_resp_i = 2'd0;
   logic [1:0]        error_o;
   logic [CNT_W-1:0]  busy_cnt_o;

   always #5 clk = ~clk;

   dmi_dtm_ctrl #(
      .ABITS       (ABITS),
      .DATA_W      (DATA_W),
      .IDLE_HINT   (1),
      .TIMEOUT_CYC (8),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .dmi_clear_i      (dmi_clear_i),
      .capture_i        (capture_i),
      .shift_i          (shift_i),
      .update_i         (update_i),
      .tdi_i            (tdi_i),
      .dtmcs_select_i   (dtmcs_select_i),
      .dmi_select_i     (dmi_select_i),
      .dtmcs_tdo_o      (dtmcs_tdo_o),
      .dmi_tdo_o        (dmi_tdo_o),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_req_addr_o   (dmi_req_addr_o),
      .dmi_req_data_o   (dmi_req_data_o),
      .dmi_req_op_o     (dmi_req_op_o),
      .dmi_resp_valid_i (dmi_resp_valid_i),
      .dmi_resp_ready_o (dmi_resp_ready_o),
      .dmi_resp_data_i  (dmi_resp_data_i),
      .dmi_resp_resp_i  (dmi_resp_resp_i),
      .error_o          (error_o),
      .busy_cnt_o       (busy_cnt_o)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_req    = 0;
   logic [63:0] req_q[$];
   logic [63:0] cap_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] dr(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] s);
      return {23'b0, a, d, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scan(input bit sel_dmi, input int unsigned len, input logic [63:0] din,
                       input bit do_upd, output logic [63:0] dout);
      dout = '0;
      dtmcs_select_i = ~sel_dmi;
      dmi_select_i   = sel_dmi;
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      for (int unsigned i = 0; i < len; i++) begin
         dout[i] = sel_dmi ? dmi_tdo_o : dtmcs_tdo_o;
         tdi_i   = din[i];
         shift_i = 1'b1;
         tick();
      end
      shift_i = 1'b0;
      tdi_i   = 1'b0;
      if (do_upd) begin
         update_i = 1'b1;
         tick();
         update_i = 1'b0;
      end
      dtmcs_select_i = 1'b0;
      dmi_select_i   = 1'b0;
   endtask

   task automatic scan_chk(input string tag, input bit sel_dmi, input logic [63:0] din,
                           input bit do_upd);
      logic [63:0] got, exp;
      scan(sel_dmi, sel_dmi ? W : 32, din, do_upd, got);
      exp = cap_q.pop_front();
      chk(tag, got, exp);
   endtask

   task automatic respond(input logic [1:0] st, input logic [31:0] d);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_resp_i  = st;
      dmi_resp_data_i  = d;
      tick();
      dmi_resp_valid_i = 1'b0;
      dmi_resp_resp_i  = 2'd0;
      dmi_resp_data_i  = '0;
   endtask

   // Request monitor: every accepted request must match the next queued one.
   always @(negedge clk) begin
      if (!rst && dmi_req_valid_o && dmi_req_ready_i) begin
         n_req++;
         n_assert++;
         assert (req_q.size() != 0) else begin
            n_fail++;
            $error("FAIL req_unexpected: observed 0x%0h expected none",
                   {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o});
         end
         if (req_q.size() != 0) begin
            chk("req", dr(dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o), req_q.pop_front());
         end
      end
   end

   initial begin
      // reset
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", 64'(dmi_req_valid_o), 64'd0);
      chk("rst_op", 64'(dmi_req_op_o), 64'd1);
      chk("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
      chk("rst_error", 64'(error_o), 64'd0);
      chk("rst_busy_cnt", 64'(busy_cnt_o), 64'd0);
      chk("rst_addr_data", 64'({dmi_req_addr_o, dmi_req_data_o}), 64'd0);
      chk("rst_tdo", 64'({dtmcs_tdo_o, dmi_tdo_o}), 64'd0);

      // dtmcs readout
      cap_q.push_back(64'h0000_1071);
      scan_chk("dtmcs_cap", 1'b0, 64'd0, 1'b1);

      // read, accepted at once, ok response after 3 cycles
      dmi_req_ready_i = 1'b1;
      req_q.push_back(dr(7'h10, 32'h0, 2'd1));
      cap_q.push_back(64'd0);
      scan_chk("read_issue_cap", 1'b1, dr(7'h10, 32'h0, 2'd1), 1'b1);
      chk("read_valid", 64'(dmi_req_valid_o), 64'd1);
      tick();
      dmi_req_ready_i = 1'b0;
      repeat (3) tick();
      respond(2'd0, 32'h1234_5678);
      chk("read_data", 64'(dmi_req_data_o), 64'h1234_5678);
      cap_q.push_back(dr(7'h10, 32'h1234_5678, 2'd0));
      scan_chk("read_result_cap", 1'b1, 64'd0, 1'b0);
      chk("read_req_count", 64'(n_req), 64'd1);

      // write held off by ready for 5 cycles, then fails
      req_q.push_back(dr(7'h04, 32'hA5A5_A5A5, 2'd2));
      cap_q.push_back(dr(7'h10, 32'h1234_5678, 2'd0));
      scan_chk("write_issue_cap", 1'b1, dr(7'h04, 32'hA5A5_A5A5, 2'd2), 1'b1);
      for (int k = 0; k < 5; k++) begin
         chk("write_hold", dr(dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o),
             dr(7'h04, 32'hA5A5_A5A5, 2'd2));
         chk("write_hold_valid", 64'(dmi_req_valid_o), 64'd1);
         tick();
      end
      dmi_req_ready_i = 1'b1;
      tick();
      dmi_req_ready_i = 1'b0;
      chk("write_wait_valid", 64'(dmi_req_valid_o), 64'd0);
      respond(2'd2, 32'h0);
      chk("write_fail_err", 64'(error_o), 64'd2);
      cap_q.push_back(dr(7'h04, 32'hA5A5_A5A5, 2'd2));
      scan_chk("err_blocked_cap", 1'b1, dr(7'h11, 32'h0, 2'd1), 1'b1);
      repeat (3) tick();
      chk("err_blocked_valid", 64'(dmi_req_valid_o), 64'd0);
      chk("err_blocked_count", 64'(n_req), 64'd2);
      cap_q.push_back(64'h0000_1871);
      scan_chk("dmireset_cap", 1'b0, 64'h0001_0000, 1'b1);
      chk("dmireset_err", 64'(error_o), 64'd0);

      // update during Wait of a write -> busy
      dmi_req_ready_i = 1'b1;
      req_q.push_back(dr(7'h22, 32'h0BAD_F00D, 2'd2));
      cap_q.push_back(dr(7'h04, 32'hA5A5_A5A5, 2'd0));
      scan_chk("busy_issue_cap", 1'b1, dr(7'h22, 32'h0BAD_F00D, 2'd2), 1'b1);
      tick();
      dmi_req_ready_i = 1'b0;
      cap_q.push_back(dr(7'h22, 32'h0BAD_F00D, 2'd0));
      scan_chk("busy_wait_cap", 1'b1, dr(7'h7F, 32'hFFFF_FFFF, 2'd1), 1'b1);
      chk("busy_err", 64'(error_o), 64'd3);
      chk("busy_cnt1", 64'(busy_cnt_o), 64'd1);
      respond(2'd0, 32'h0);
      cap_q.push_back(dr(7'h22, 32'h0BAD_F00D, 2'd3));
      scan_chk("busy_stat_cap", 1'b1, 64'd0, 1'b0);
      cap_q.push_back(64'h0000_1C71);
      scan_chk("busy_dmireset_cap", 1'b0, 64'h0001_0000, 1'b1);
      chk("busy_cleared_err", 64'(error_o), 64'd0);
      chk("busy_cnt_kept", 64'(busy_cnt_o), 64'd1);

      // hard clear while a request is pending and not accepted
      cap_q.push_back(dr(7'h22, 32'h0BAD_F00D, 2'd0));
      scan_chk("hc_issue_cap", 1'b1, dr(7'h33, 32'h0, 2'd1), 1'b1);
      chk("hc_valid_before", 64'(dmi_req_valid_o), 64'd1);
      cap_q.push_back(64'h0000_1071);
      scan_chk("hc_dtmcs_cap", 1'b0, 64'h0002_0000, 1'b1);
      chk("hc_valid_after", 64'(dmi_req_valid_o), 64'd0);
      chk("hc_state", dr(dmi_req_addr_o, dmi_req_data_o, error_o), 64'd0);
      chk("hc_busy_cnt", 64'(busy_cnt_o), 64'd0);
      respond(2'd0, 32'hFFFF_FFFF);
      chk("hc_late_resp_data", 64'(dmi_req_data_o), 64'd0);
      cap_q.push_back(64'd0);
      scan_chk("hc_dr_cap", 1'b1, 64'd0, 1'b0);

      // busy counter saturation: capture and update both busy while in Req of a read
      cap_q.push_back(64'd0);
      scan_chk("sat_issue_cap", 1'b1, dr(7'h01, 32'h0, 2'd1), 1'b1);
      for (int k = 1; k <= 4; k++) begin
         cap_q.push_back(dr(7'h01, 32'h0, 2'd3));
         scan_chk("sat_busy_cap", 1'b1, dr(7'h7F, 32'hFFFF_FFFF, 2'd1), 1'b1);
         chk("sat_cnt", 64'(busy_cnt_o), (2 * k > 7) ? 64'd7 : 64'(2 * k));
      end
      chk("sat_addr_held", 64'(dmi_req_addr_o), 64'h01);
      req_q.push_back(dr(7'h01, 32'h0, 2'd1));
      dmi_req_ready_i = 1'b1;
      tick();
      dmi_req_ready_i = 1'b0;
      respond(2'd0, 32'hCAFE_F00D);
      cap_q.push_back(dr(7'h01, 32'hCAFE_F00D, 2'd3));
      scan_chk("sat_result_cap", 1'b1, 64'd0, 1'b0);
      dmi_clear_i = 1'b1;
      tick();
      dmi_clear_i = 1'b0;
      chk("tlr_clear", dr(dmi_req_addr_o, dmi_req_data_o, error_o), 64'd0);
      chk("tlr_busy_cnt", 64'(busy_cnt_o), 64'd0);

      // no response: timeout build gives up, default build keeps waiting
      dmi_req_ready_i = 1'b1;
      req_q.push_back(dr(7'h05, 32'h0, 2'd1));
      cap_q.push_back(64'd0);
      scan_chk("to_issue_cap", 1'b1, dr(7'h05, 32'h0, 2'd1), 1'b1);
      tick();
      dmi_req_ready_i = 1'b0;
`ifdef DMI_RESP_TIMEOUT_EN
      repeat (7) tick();
      chk("to_not_yet", 64'(error_o), 64'd0);
      tick();
      chk("to_err", 64'(error_o), 64'd2);
      chk("to_valid", 64'(dmi_req_valid_o), 64'd0);
      cap_q.push_back(dr(7'h05, 32'hDEAD_BEEF, 2'd2));
      scan_chk("to_cap", 1'b1, 64'd0, 1'b0);
      respond(2'd0, 32'h1111_1111);
      chk("to_late_discard", 64'(dmi_req_data_o), 64'hDEAD_BEEF);
`else
      repeat (20) tick();
      chk("wait_blocks_err", 64'(error_o), 64'd0);
      respond(2'd0, 32'h5A5A_5A5A);
      chk("wait_resp_data", 64'(dmi_req_data_o), 64'h5A5A_5A5A);
`endif

      chk("req_count_final", 64'(n_req), 64'd5);
      chk("req_queue_empty", 64'(req_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
